spi_prefetch_fetch: RTL and testbench

- Parametrised successor to the single-word SPI program-memory fetcher.
- Streams instructions from an external SPI flash using one READ command per contiguous run, rather than one transaction per PC value.
- Buffers words in a DEPTH-entry prefetch FIFO tagged with their word addresses, and restarts the stream on a branch flush.
- Sits between the SPI pins (uio) and the CPU fetch/decode stage.

---
 rtl/spi_prefetch_fetch.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_prefetch_fetch.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_prefetch_fetch.sv
// -----------------------------------------------------------------------------
// spi_prefetch_fetch
//
// Streams CPU instructions from an external SPI flash (mode 0, sclk = clk/2).
// One READ command is issued per contiguous run of word addresses. Incoming
// words go into a DEPTH-entry prefetch FIFO tagged with their word address.
// A branch flush discards everything buffered or in flight and restarts the
// stream at flush_addr.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   flush          discard buffered/in-flight words, restart at flush_addr
//   flush_addr     word address to restart at
//   instr_ready    consumer accepts the head word this cycle
//   instr_valid    FIFO non-empty
//   instr          head word (zero while instr_valid is low)
//   instr_addr     word address of the head word (zero while instr_valid low)
//   spi_cs         chip select, active-low
//   spi_sclk       SPI clock
//   spi_mosi       serial data to flash, spi_mosi_oe its output enable
//   spi_miso       serial data from flash
// -----------------------------------------------------------------------------
module spi_prefetch_fetch #(
  parameter int         INSTR_W    = 16,
  parameter int         ADDR_W     = 16,
  parameter int         DEPTH      = 4,
  parameter int         RESET_ADDR = 0,
  parameter int         CS_GAP     = 2,
  parameter logic [7:0] READ_CMD   = 8'h03
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_addr,
  input  logic               instr_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic               spi_cs,
  output logic               spi_sclk,
  output logic               spi_mosi,
  output logic               spi_mosi_oe,
  input  logic               spi_miso
);

  localparam int BYTES = INSTR_W / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2((INSTR_W > 24) ? INSTR_W : 24);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [2:0] ST_GAP   = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  logic [2:0]         state;
  logic [GAP_W-1:0]   gap_cnt;
  logic               ph;          // bit phase: 0 = sclk low, 1 = sclk high
  logic [BIT_W-1:0]   bit_cnt;     // bit index within the current state
  logic [ADDR_W-1:0]  fetch_addr;  // word address of the word being received
  logic [31:0]        tx_sr;       // opcode + 24-bit byte address, MSB first
  logic [INSTR_W-2:0] rx_sr;       // bits received so far of the current word

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [INSTR_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0]  fifo_addr [DEPTH];

  logic               shifting;
  logic               tx_phase;
  logic               word_end;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] word_in;
  logic [23:0]        byte_addr;

  assign shifting  = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
  assign tx_phase  = (state == ST_CMD) || (state == ST_ADDR);

  // miso is sampled on the edge that ends the sclk-high phase, so the word
  // completes on that edge with the live miso bit as its LSB.
  assign word_end  = (state == ST_DATA) && ph && (bit_cnt == BIT_W'(INSTR_W - 1));
  assign word_in   = {rx_sr, spi_miso};
  assign push      = word_end && !flush;
  assign pop       = instr_valid && instr_ready && !flush;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  assign byte_addr = 24'(48'(fetch_addr) * 48'(BYTES));

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_addr  = instr_valid ? fifo_addr[rd_ptr] : '0;

  // Pin outputs decode straight from state so an asynchronous reset
  // releases the bus without waiting for a clock edge.
  assign spi_cs      = (state == ST_GAP);
  assign spi_sclk    = shifting && ph;
  assign spi_mosi_oe = tx_phase;
  assign spi_mosi    = tx_phase && tx_sr[31];

  // Control: sequencer, fetch address and FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_GAP;
      gap_cnt    <= '0;
      ph         <= 1'b0;
      bit_cnt    <= '0;
      fetch_addr <= ADDR_W'(RESET_ADDR);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else if (flush) begin
      state      <= ST_GAP;
      gap_cnt    <= '0;
      ph         <= 1'b0;
      bit_cnt    <= '0;
      fetch_addr <= flush_addr;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;

      case (state)
        ST_GAP: begin
          ph      <= 1'b0;
          bit_cnt <= '0;
          if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
            state   <= ST_CMD;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        ST_CMD: begin
          ph <= ~ph;
          if (ph) begin
            if (bit_cnt == BIT_W'(7)) begin
              state   <= ST_ADDR;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        ST_ADDR: begin
          ph <= ~ph;
          if (ph) begin
            if (bit_cnt == BIT_W'(23)) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        ST_DATA: begin
          ph <= ~ph;
          if (ph) begin
            if (word_end) begin
              bit_cnt    <= '0;
              fetch_addr <= fetch_addr + ADDR_W'(1);
              // The last word of the address space closes the transaction
              // so the flash never reads past the ADDR_W range.
              if (&fetch_addr) begin
                state <= ST_GAP;
              end else if (count_nxt == CNT_W'(DEPTH)) begin
                state <= ST_PAUSE;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        ST_PAUSE: begin
          // cs stays low; the read simply resumes once a slot frees up.
          ph <= 1'b0;
          if (count_nxt < CNT_W'(DEPTH)) state <= ST_DATA;
        end

        default: begin
          state   <= ST_GAP;
          gap_cnt <= '0;
          ph      <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Data: shift registers and FIFO storage (not reset)
  always_ff @(posedge clk) begin
    // Reloaded every GAP cycle so the header always tracks the latest
    // fetch address, including one just written by a flush.
    if (state == ST_GAP) begin
      tx_sr <= {READ_CMD, byte_addr};
    end else if (tx_phase && ph) begin
      tx_sr <= {tx_sr[30:0], 1'b0};
    end

    if ((state == ST_DATA) && ph) begin
      rx_sr <= word_in[INSTR_W-2:0];
    end

    if (push) begin
      fifo_data[wr_ptr] <= word_in;
      fifo_addr[wr_ptr] <= fetch_addr;
    end
  end

endmodule

// File: tb/tb_spi_prefetch_fetch.sv
// -----------------------------------------------------------------------------
// tb_spi_prefetch_fetch
//
// Bench for spi_prefetch_fetch with a behavioural SPI flash. Expected words
// are queued when stimulus is set up; a monitor pops and compares them when
// the DUT hands a word over. Header bytes and cycle timing are checked by the
// directed test sequence.
// -----------------------------------------------------------------------------
module tb_spi_prefetch_fetch;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] flush_addr = 16'h0000;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_addr;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_mosi_oe;
  logic        spi_miso = 1'b0;

  spi_prefetch_fetch #(
    .INSTR_W   (16),
    .ADDR_W    (16),
    .DEPTH     (4),
    .RESET_ADDR(0),
    .CS_GAP    (2),
    .READ_CMD  (8'h03)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .flush_addr (flush_addr),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_addr (instr_addr),
    .spi_cs     (spi_cs),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_mosi_oe(spi_mosi_oe),
    .spi_miso   (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          ready_en = 1'b0;
  int          pop_cyc = 0;
  exp_t        exp_q[$];
  logic [31:0] hdr_q[$];
  int          rise_q[$];
  int          fall_q[$];
  int          csrise_q[$];
  logic [7:0]  fmem [logic [23:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    if (fmem.exists(a)) return fmem[a];
    return 8'hEE;
  endfunction

  task automatic push_exp(input logic [15:0] d, input logic [15:0] a);
    exp_t e;
    e.data = d;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: a handover is seen when valid and ready are both
  // high in the middle of the cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: word 0x%0h @0x%0h with nothing expected", instr, instr_addr);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", 64'(instr), 64'(e.data));
          check("sb_addr", 64'(instr_addr), 64'(e.addr));
          pop_cyc = cyc;
        end
      end
    end
  end

  // Consumer accepts only while it is still expecting words.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      instr_ready = ready_en && (exp_q.size() != 0) && !rst;
    end
  end

  // Edge recorders for timing checks.
  initial begin
    logic pv;
    logic pcs;
    pv  = 1'b0;
    pcs = 1'b1;
    forever begin
      @(negedge clk);
      if (instr_valid && !pv) rise_q.push_back(cyc);
      if (!spi_cs && pcs)     fall_q.push_back(cyc);
      if (spi_cs && !pcs)     csrise_q.push_back(cyc);
      pv  = instr_valid;
      pcs = spi_cs;
    end
  end

  // SPI flash: mosi captured and miso driven during each sclk-high cycle,
  // ahead of the DUT sampling edge that ends it.
  initial begin
    int          fbit;
    int          d;
    logic [31:0] fhdr;
    logic [23:0] fstart;
    logic [7:0]  b;
    fbit   = 0;
    fhdr   = '0;
    fstart = '0;
    forever begin
      @(negedge clk);
      if (spi_cs) begin
        fbit = 0;
      end else if (spi_sclk) begin
        if (fbit < 32) begin
          fhdr = {fhdr[30:0], spi_mosi};
          if (fbit == 31) begin
            hdr_q.push_back(fhdr);
            fstart = fhdr[23:0];
          end
        end else begin
          d = fbit - 32;
          b = fbyte(fstart + 24'(d / 8));
          spi_miso = b[7 - (d % 8)];
        end
        fbit++;
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fall(input string name, output int c);
    int k = 0;
    c = 0;
    while (fall_q.size() == 0 && k < 400) begin @(negedge clk); k++; end
    if (fall_q.size() == 0) timeout(name);
    else c = fall_q.pop_front();
  endtask

  task automatic wait_csrise(input string name, output int c);
    int k = 0;
    c = 0;
    while (csrise_q.size() == 0 && k < 400) begin @(negedge clk); k++; end
    if (csrise_q.size() == 0) timeout(name);
    else c = csrise_q.pop_front();
  endtask

  task automatic wait_rise(input string name, output int c);
    int k = 0;
    c = 0;
    while (rise_q.size() == 0 && k < 400) begin @(negedge clk); k++; end
    if (rise_q.size() == 0) timeout(name);
    else c = rise_q.pop_front();
  endtask

  task automatic wait_hdr(input string name, input logic [31:0] exp);
    int k = 0;
    while (hdr_q.size() == 0 && k < 400) begin @(negedge clk); k++; end
    if (hdr_q.size() == 0) timeout(name);
    else check(name, 64'(hdr_q.pop_front()), 64'(exp));
  endtask

  task automatic wait_empty(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 600) begin @(negedge clk); k++; end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready_en = 1'b0;
    wait_n(2);
    exp_q.delete();
    hdr_q.delete();
    fmem.delete();
  endtask

  task automatic release_rst(output int rel);
    rise_q.delete();
    fall_q.delete();
    csrise_q.delete();
    rel = cyc;
    rst = 1'b0;
  endtask

  initial begin
    int          rel;
    int          c;
    int          c2;
    int          r;
    int          f1;
    int          n_sclk;
    int          n_cs;
    int          k;

    // ---- Reset release, first word ----
    do_reset();
    check("rst_cs", 64'(spi_cs), 64'd1);
    check("rst_sclk", 64'(spi_sclk), 64'd0);
    check("rst_mosi", 64'(spi_mosi), 64'd0);
    check("rst_oe", 64'(spi_mosi_oe), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_addr", 64'(instr_addr), 64'd0);
    fmem[24'h000000] = 8'h12;
    fmem[24'h000001] = 8'h34;
    push_exp(16'h1234, 16'h0000);
    ready_en = 1'b1;
    release_rst(rel);
    wait_fall("t1_cs_fall", c);
    check("t1_cs_fall_cycle", 64'(c - rel), 64'd2);
    wait_hdr("t1_header", 32'h03000000);
    wait_rise("t1_valid_rise", r);
    check("t1_valid_latency", 64'(r - c), 64'd96);
    wait_empty("t1_drain");

    // ---- Continuous stream ----
    do_reset();
    fmem[24'h000000] = 8'hA0; fmem[24'h000001] = 8'h01;
    fmem[24'h000002] = 8'hA0; fmem[24'h000003] = 8'h02;
    fmem[24'h000004] = 8'hA0; fmem[24'h000005] = 8'h03;
    push_exp(16'hA001, 16'h0000);
    push_exp(16'hA002, 16'h0001);
    push_exp(16'hA003, 16'h0002);
    ready_en = 1'b1;
    release_rst(rel);
    wait_fall("t2_cs_fall", c);
    wait_rise("t2_rise0", r);
    check("t2_rise0_offset", 64'(r - c), 64'd96);
    wait_rise("t2_rise1", r);
    check("t2_rise1_offset", 64'(r - c), 64'd128);
    wait_rise("t2_rise2", r);
    check("t2_rise2_offset", 64'(r - c), 64'd160);
    wait_empty("t2_drain");
    wait_until(c + 170);
    check("t2_cs_held_low", 64'(csrise_q.size()), 64'd0);

    // ---- Back-pressure into PAUSE ----
    do_reset();
    for (int i = 0; i < 6; i++) begin
      fmem[24'(2 * i)]     = 8'hB0;
      fmem[24'(2 * i + 1)] = 8'(i);
    end
    release_rst(rel);
    wait_fall("t3_cs_fall", c);
    wait_until(c + 200);
    check("t3_full_valid", 64'(instr_valid), 64'd1);
    check("t3_head_instr", 64'(instr), 64'hB000);
    check("t3_head_addr", 64'(instr_addr), 64'd0);
    n_sclk = 0;
    n_cs   = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (spi_sclk) n_sclk++;
      if (spi_cs)   n_cs++;
    end
    check("t3_pause_sclk_high", 64'(n_sclk), 64'd0);
    check("t3_pause_cs_high", 64'(n_cs), 64'd0);
    check("t3_head_stable", 64'(instr), 64'hB000);
    push_exp(16'hB000, 16'h0000);
    ready_en = 1'b1;
    wait_empty("t3_first_pop");
    k = 0;
    do begin @(negedge clk); k++; end while (!spi_sclk && k < 50);
    if (!spi_sclk) timeout("t3_resume");
    else check("t3_resume_offset", 64'(cyc - pop_cyc), 64'd2);
    push_exp(16'hB001, 16'h0001);
    push_exp(16'hB002, 16'h0002);
    push_exp(16'hB003, 16'h0003);
    push_exp(16'hB004, 16'h0004);
    wait_empty("t3_drain");

    // ---- Flush mid-DATA ----
    do_reset();
    for (int i = 0; i < 6; i++) begin
      fmem[24'(2 * i)]     = 8'hC0;
      fmem[24'(2 * i + 1)] = 8'(i);
    end
    fmem[24'h000200] = 8'hD1;
    fmem[24'h000201] = 8'h00;
    release_rst(rel);
    wait_fall("t4_cs_fall", c);
    wait_until(c + 140);
    check("t4_pre_valid", 64'(instr_valid), 64'd1);
    check("t4_pre_instr", 64'(instr), 64'hC000);
    hdr_q.delete();
    flush_addr = 16'h0100;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    f1 = cyc;
    check("t4_flush_valid", 64'(instr_valid), 64'd0);
    check("t4_flush_cs", 64'(spi_cs), 64'd1);
    wait_fall("t4_cs_refall", c2);
    check("t4_cs_high_cycles", 64'(c2 - f1), 64'd2);
    wait_hdr("t4_header", 32'h03000200);
    push_exp(16'hD100, 16'h0100);
    ready_en = 1'b1;
    wait_empty("t4_drain");

    // ---- Address wrap at 0xFFFF ----
    fmem[24'h01FFFE] = 8'hEF;
    fmem[24'h01FFFF] = 8'hFE;
    fmem[24'h000000] = 8'h5A;
    fmem[24'h000001] = 8'hA5;
    hdr_q.delete();
    flush_addr = 16'hFFFF;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    push_exp(16'hEFFE, 16'hFFFF);
    push_exp(16'h5AA5, 16'h0000);
    wait_hdr("t5_header_top", 32'h0301FFFE);
    csrise_q.delete();
    fall_q.delete();
    wait_csrise("t5_cs_rise", r);
    wait_fall("t5_cs_fall", c2);
    check("t5_gap_cycles", 64'(c2 - r), 64'd2);
    wait_hdr("t5_header_wrap", 32'h03000000);
    wait_empty("t5_drain");

    // ---- Asynchronous reset during ADDR ----
    do_reset();
    fmem[24'h000000] = 8'h66;
    fmem[24'h000001] = 8'h99;
    release_rst(rel);
    wait_fall("t6_cs_fall", c);
    wait_until(c + 20);
    k = 0;
    while (!spi_sclk && k < 10) begin @(negedge clk); k++; end
    check("t6_in_addr_oe", 64'(spi_mosi_oe), 64'd1);
    check("t6_in_addr_sclk", 64'(spi_sclk), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_cs", 64'(spi_cs), 64'd1);
    check("t6_async_sclk", 64'(spi_sclk), 64'd0);
    check("t6_async_valid", 64'(instr_valid), 64'd0);
    check("t6_async_oe", 64'(spi_mosi_oe), 64'd0);
    wait_n(2);
    hdr_q.delete();
    exp_q.delete();
    push_exp(16'h6699, 16'h0000);
    ready_en = 1'b1;
    release_rst(rel);
    wait_fall("t6_cs_refall", c);
    check("t6_restart_fall_cycle", 64'(c - rel), 64'd2);
    wait_hdr("t6_header", 32'h03000000);
    wait_empty("t6_drain");

    wait_n(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
